// File: rtl/branch_update_queue_pkg.sv
// Shared definitions for the branch update queue.
//   BQ_ADDR_W  : default instruction address width
//   BQ_DEPTH   : default number of queue entries
//   INST_SIZE  : byte size of one instruction (fall-through PC step)
//   bq_entry_t : one queued predictor update {pc, taken} at the default width
package branch_update_queue_pkg;

  localparam int BQ_ADDR_W = 32;
  localparam int BQ_DEPTH  = 4;
  localparam int INST_SIZE = 4;

  typedef struct packed {
    logic [BQ_ADDR_W-1:0] pc;
    logic                 taken;
  } bq_entry_t;

endpackage

// File: rtl/branch_update_queue_if.sv
// Bus between EX / predictor / fetch and the branch update queue.
//   rdy                      : global ready, low freezes the queue
//   br_valid_i .. br_target_i: resolved branch from EX (br_ready_o back)
//   flush_o, redirect_pc_o   : registered mispredict pulse and corrected PC
//   upd_ready_i, we_o, waddr_o, res_taken_o : predictor write port
//   stat_branch_o, stat_miss_o              : running statistics
// The master modport is the environment side, slave is the queue side.
interface branch_update_queue_if
  import branch_update_queue_pkg::*;
#(
  parameter int ADDR_W = BQ_ADDR_W
) ();

  logic              rdy;
  logic              br_valid_i;
  logic              br_ready_o;
  logic [ADDR_W-1:0] br_pc_i;
  logic              br_taken_i;
  logic              br_pred_i;
  logic [ADDR_W-1:0] br_target_i;
  logic              flush_o;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic              upd_ready_i;
  logic              we_o;
  logic [ADDR_W-1:0] waddr_o;
  logic              res_taken_o;
  logic [31:0]       stat_branch_o;
  logic [31:0]       stat_miss_o;

  modport master (
    output rdy, br_valid_i, br_pc_i, br_taken_i, br_pred_i, br_target_i,
           upd_ready_i,
    input  br_ready_o, flush_o, redirect_pc_o, we_o, waddr_o, res_taken_o,
           stat_branch_o, stat_miss_o
  );

  modport slave (
    input  rdy, br_valid_i, br_pc_i, br_taken_i, br_pred_i, br_target_i,
           upd_ready_i,
    output br_ready_o, flush_o, redirect_pc_o, we_o, waddr_o, res_taken_o,
           stat_branch_o, stat_miss_o
  );

endinterface

// File: rtl/branch_update_queue_bq_fifo.sv
// bq_fifo: generic synchronous FIFO with a combinational head view.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push       : write push_data at the tail (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   full/empty : occupancy flags
//   head       : current head entry, all zeros when empty
module bq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);

  // A full FIFO refuses a push even when it pops in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset: stale contents are masked by the empty flag.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/branch_update_queue.sv
// branch_update_queue: checks resolved branches against their prediction,
// raises a one-cycle flush with the corrected PC on a mismatch, and queues
// every accepted outcome for the predictor write port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : branch_update_queue_if slave modport (see interface file)
module branch_update_queue
  import branch_update_queue_pkg::*;
#(
  parameter int DEPTH  = BQ_DEPTH,
  parameter int ADDR_W = BQ_ADDR_W
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_update_queue_if.slave bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              taken;
  } entry_t;

  entry_t            push_entry;
  entry_t            head_entry;
  logic              full;
  logic              empty;
  logic              accept;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_next;

  logic              flush_reg;
  logic [ADDR_W-1:0] redirect_reg;
  logic [31:0]       stat_branch_reg;
  logic [31:0]       stat_miss_reg;

  // The cycle showing flush is wrong-path, so nothing is taken from EX then.
  assign accept     = bus.rdy && bus.br_valid_i && !full && !flush_reg;
  assign mispredict = accept && (bus.br_taken_i != bus.br_pred_i);

  assign redirect_next = bus.br_taken_i ? bus.br_target_i
                                        : bus.br_pc_i + ADDR_W'(INST_SIZE);

  assign push_entry.pc    = bus.br_pc_i;
  assign push_entry.taken = bus.br_taken_i;

  bq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (push_entry),
    .pop       (bus.we_o),
    .full      (full),
    .empty     (empty),
    .head      (head_entry)
  );

  // Write port pops the head in the same cycle it is written.
  assign bus.we_o        = bus.rdy && !empty && bus.upd_ready_i;
  assign bus.waddr_o     = head_entry.pc;
  assign bus.res_taken_o = head_entry.taken;
  assign bus.br_ready_o  = !full;

  // Everything holds while rdy is low, including a pending flush pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_reg       <= 1'b0;
      redirect_reg    <= '0;
      stat_branch_reg <= '0;
      stat_miss_reg   <= '0;
    end else if (bus.rdy) begin
      flush_reg <= mispredict;
      if (mispredict) begin
        redirect_reg  <= redirect_next;
        stat_miss_reg <= stat_miss_reg + 32'd1;
      end
      if (accept) begin
        stat_branch_reg <= stat_branch_reg + 32'd1;
      end
    end
  end

  assign bus.flush_o       = flush_reg;
  assign bus.redirect_pc_o = redirect_reg;
  assign bus.stat_branch_o = stat_branch_reg;
  assign bus.stat_miss_o   = stat_miss_reg;

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed self-checking bench for branch_update_queue.
// Inputs change 1 ns after the rising edge, outputs are checked 3 ns after it.
module tb_branch_update_queue;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  branch_update_queue_if #(.ADDR_W(32)) bus ();

  branch_update_queue #(
    .DEPTH  (4),
    .ADDR_W (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic tk,
                       input logic pr, input logic [31:0] tgt);
    bus.br_valid_i  = v;
    bus.br_pc_i     = pc;
    bus.br_taken_i  = tk;
    bus.br_pred_i   = pr;
    bus.br_target_i = tgt;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    idle();
    bus.rdy = 1'b1;
    bus.upd_ready_i = 1'b0;
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (bus.flush_o !== 1'b0) begin n_bad++; $display("FAIL reset_flush: got %b expected 0", bus.flush_o); end
    n_cmp++; if (bus.redirect_pc_o !== 32'h0) begin n_bad++; $display("FAIL reset_redirect: got %h expected 0", bus.redirect_pc_o); end
    n_cmp++; if (bus.we_o !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b expected 0", bus.we_o); end
    n_cmp++; if (bus.waddr_o !== 32'h0) begin n_bad++; $display("FAIL reset_waddr: got %h expected 0", bus.waddr_o); end
    n_cmp++; if (bus.res_taken_o !== 1'b0) begin n_bad++; $display("FAIL reset_res: got %b expected 0", bus.res_taken_o); end
    n_cmp++; if (bus.stat_branch_o !== 32'd0) begin n_bad++; $display("FAIL reset_stat_branch: got %0d expected 0", bus.stat_branch_o); end
    n_cmp++; if (bus.stat_miss_o !== 32'd0) begin n_bad++; $display("FAIL reset_stat_miss: got %0d expected 0", bus.stat_miss_o); end
    n_cmp++; if (bus.br_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", bus.br_ready_o); end
    cyc();
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_correct_pred();
    bus.upd_ready_i = 1'b1;
    drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h0);
    #2;
    n_cmp++; if (bus.br_ready_o !== 1'b1) begin n_bad++; $display("FAIL cp_ready: got %b expected 1", bus.br_ready_o); end
    n_cmp++; if (bus.we_o !== 1'b0) begin n_bad++; $display("FAIL cp_no_bypass: got %b expected 0", bus.we_o); end
    cyc();
    idle();
    #2;
    n_cmp++; if (bus.we_o !== 1'b1) begin n_bad++; $display("FAIL cp_we: got %b expected 1", bus.we_o); end
    n_cmp++; if (bus.waddr_o !== 32'h100) begin n_bad++; $display("FAIL cp_waddr: got %h expected 100", bus.waddr_o); end
    n_cmp++; if (bus.res_taken_o !== 1'b1) begin n_bad++; $display("FAIL cp_res: got %b expected 1", bus.res_taken_o); end
    n_cmp++; if (bus.flush_o !== 1'b0) begin n_bad++; $display("FAIL cp_flush: got %b expected 0", bus.flush_o); end
    n_cmp++; if (bus.stat_branch_o !== 32'd1) begin n_bad++; $display("FAIL cp_stat_branch: got %0d expected 1", bus.stat_branch_o); end
    n_cmp++; if (bus.stat_miss_o !== 32'd0) begin n_bad++; $display("FAIL cp_stat_miss: got %0d expected 0", bus.stat_miss_o); end
    cyc();
    #2;
    n_cmp++; if (bus.we_o !== 1'b0) begin n_bad++; $display("FAIL cp_drained_we: got %b expected 0", bus.we_o); end
    n_cmp++; if (bus.waddr_o !== 32'h0) begin n_bad++; $display("FAIL cp_drained_waddr: got %h expected 0", bus.waddr_o); end
    cyc();
    $display("test_correct_pred done");
  endtask

  task automatic test_mispredict();
    do_reset();
    bus.upd_ready_i = 1'b1;
    drive(1'b1, 32'h200, 1'b0, 1'b1, 32'h400);
    cyc();
    // valid held through the flush cycle must be dropped
    #2;
    n_cmp++; if (bus.flush_o !== 1'b1) begin n_bad++; $display("FAIL mp_flush: got %b expected 1", bus.flush_o); end
    n_cmp++; if (bus.redirect_pc_o !== 32'h204) begin n_bad++; $display("FAIL mp_redirect: got %h expected 204", bus.redirect_pc_o); end
    n_cmp++; if (bus.stat_miss_o !== 32'd1) begin n_bad++; $display("FAIL mp_stat_miss: got %0d expected 1", bus.stat_miss_o); end
    n_cmp++; if (bus.waddr_o !== 32'h200) begin n_bad++; $display("FAIL mp_waddr: got %h expected 200", bus.waddr_o); end
    n_cmp++; if (bus.res_taken_o !== 1'b0) begin n_bad++; $display("FAIL mp_res: got %b expected 0", bus.res_taken_o); end
    cyc();
    drive(1'b1, 32'h300, 1'b1, 1'b0, 32'h480);
    #2;
    n_cmp++; if (bus.flush_o !== 1'b0) begin n_bad++; $display("FAIL mp_flush_end: got %b expected 0", bus.flush_o); end
    n_cmp++; if (bus.stat_branch_o !== 32'd1) begin n_bad++; $display("FAIL mp_dropped: got %0d expected 1", bus.stat_branch_o); end
    n_cmp++; if (bus.we_o !== 1'b0) begin n_bad++; $display("FAIL mp_dropped_we: got %b expected 0", bus.we_o); end
    cyc();
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0);
    #2;
    n_cmp++; if (bus.redirect_pc_o !== 32'h480) begin n_bad++; $display("FAIL mp_taken_redirect: got %h expected 480", bus.redirect_pc_o); end
    n_cmp++; if (bus.stat_miss_o !== 32'd2) begin n_bad++; $display("FAIL mp_stat_miss2: got %0d expected 2", bus.stat_miss_o); end
    cyc();
    #2;
    n_cmp++; if (bus.flush_o !== 1'b0) begin n_bad++; $display("FAIL mp_flush_gap: got %b expected 0", bus.flush_o); end
    n_cmp++; if (bus.stat_branch_o !== 32'd2) begin n_bad++; $display("FAIL mp_stat_branch2: got %0d expected 2", bus.stat_branch_o); end
    cyc();
    idle();
    #2;
    n_cmp++; if (bus.redirect_pc_o !== 32'h0) begin n_bad++; $display("FAIL mp_wrap_redirect: got %h expected 0", bus.redirect_pc_o); end
    n_cmp++; if (bus.stat_miss_o !== 32'd3) begin n_bad++; $display("FAIL mp_stat_miss3: got %0d expected 3", bus.stat_miss_o); end
    n_cmp++; if (bus.stat_branch_o !== 32'd3) begin n_bad++; $display("FAIL mp_stat_branch3: got %0d expected 3", bus.stat_branch_o); end
    cyc();
    $display("test_mispredict done");
  endtask

  task automatic test_full();
    logic [31:0] pc;
    do_reset();
    bus.upd_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pc = 32'h10 * (i + 1);
      drive(1'b1, pc, (i % 2) == 0, (i % 2) == 0, 32'h0);
      #2;
      n_cmp++; if (bus.br_ready_o !== (i < 4)) begin n_bad++; $display("FAIL full_ready push%0d: got %b expected %b", i, bus.br_ready_o, (i < 4)); end
      cyc();
    end
    // full with a pop in the same cycle still refuses the push
    bus.upd_ready_i = 1'b1;
    drive(1'b1, 32'h60, 1'b1, 1'b1, 32'h0);
    #2;
    n_cmp++; if (bus.br_ready_o !== 1'b0) begin n_bad++; $display("FAIL full_pop_ready: got %b expected 0", bus.br_ready_o); end
    n_cmp++; if (bus.we_o !== 1'b1) begin n_bad++; $display("FAIL full_we0: got %b expected 1", bus.we_o); end
    n_cmp++; if (bus.waddr_o !== 32'h10) begin n_bad++; $display("FAIL full_waddr0: got %h expected 10", bus.waddr_o); end
    cyc();
    idle();
    for (int i = 1; i < 4; i++) begin
      pc = 32'h10 * (i + 1);
      #2;
      n_cmp++; if (bus.we_o !== 1'b1) begin n_bad++; $display("FAIL full_we%0d: got %b expected 1", i, bus.we_o); end
      n_cmp++; if (bus.waddr_o !== pc) begin n_bad++; $display("FAIL full_waddr%0d: got %h expected %h", i, bus.waddr_o, pc); end
      n_cmp++; if (bus.res_taken_o !== ((i % 2) == 0)) begin n_bad++; $display("FAIL full_res%0d: got %b expected %b", i, bus.res_taken_o, ((i % 2) == 0)); end
      cyc();
    end
    #2;
    n_cmp++; if (bus.we_o !== 1'b0) begin n_bad++; $display("FAIL full_empty_we: got %b expected 0", bus.we_o); end
    n_cmp++; if (bus.br_ready_o !== 1'b1) begin n_bad++; $display("FAIL full_empty_ready: got %b expected 1", bus.br_ready_o); end
    n_cmp++; if (bus.stat_branch_o !== 32'd4) begin n_bad++; $display("FAIL full_stat_branch: got %0d expected 4", bus.stat_branch_o); end
    cyc();
    $display("test_full done");
  endtask

  task automatic test_push_pop();
    logic [31:0] pc;
    do_reset();
    bus.upd_ready_i = 1'b0;
    drive(1'b1, 32'hA0, 1'b1, 1'b1, 32'h0);
    cyc();
    drive(1'b1, 32'hA4, 1'b0, 1'b0, 32'h0);
    cyc();
    bus.upd_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = 32'hA8 + 32'(4 * i);
      drive(1'b1, pc, 1'b1, 1'b1, 32'h0);
      pc = 32'hA0 + 32'(4 * i);
      #2;
      n_cmp++; if (bus.br_ready_o !== 1'b1) begin n_bad++; $display("FAIL pp_ready%0d: got %b expected 1", i, bus.br_ready_o); end
      n_cmp++; if (bus.we_o !== 1'b1) begin n_bad++; $display("FAIL pp_we%0d: got %b expected 1", i, bus.we_o); end
      n_cmp++; if (bus.waddr_o !== pc) begin n_bad++; $display("FAIL pp_waddr%0d: got %h expected %h", i, bus.waddr_o, pc); end
      cyc();
    end
    idle();
    for (int j = 0; j < 2; j++) begin
      pc = 32'hAC + 32'(4 * j);
      #2;
      n_cmp++; if (bus.waddr_o !== pc) begin n_bad++; $display("FAIL pp_tail%0d: got %h expected %h", j, bus.waddr_o, pc); end
      cyc();
    end
    #2;
    n_cmp++; if (bus.we_o !== 1'b0) begin n_bad++; $display("FAIL pp_empty_we: got %b expected 0", bus.we_o); end
    cyc();
    $display("test_push_pop done");
  endtask

  task automatic test_rdy_freeze();
    do_reset();
    bus.upd_ready_i = 1'b0;
    drive(1'b1, 32'hC0, 1'b1, 1'b1, 32'h0);
    cyc();
    drive(1'b1, 32'hC4, 1'b0, 1'b1, 32'h999);
    cyc();
    bus.rdy = 1'b0;
    bus.upd_ready_i = 1'b1;
    drive(1'b1, 32'hD0, 1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #2;
      n_cmp++; if (bus.we_o !== 1'b0) begin n_bad++; $display("FAIL frz_we%0d: got %b expected 0", i, bus.we_o); end
      n_cmp++; if (bus.flush_o !== 1'b1) begin n_bad++; $display("FAIL frz_flush%0d: got %b expected 1", i, bus.flush_o); end
      n_cmp++; if (bus.redirect_pc_o !== 32'hC8) begin n_bad++; $display("FAIL frz_redirect%0d: got %h expected c8", i, bus.redirect_pc_o); end
      n_cmp++; if (bus.stat_branch_o !== 32'd2) begin n_bad++; $display("FAIL frz_stat_branch%0d: got %0d expected 2", i, bus.stat_branch_o); end
      n_cmp++; if (bus.stat_miss_o !== 32'd1) begin n_bad++; $display("FAIL frz_stat_miss%0d: got %0d expected 1", i, bus.stat_miss_o); end
      n_cmp++; if (bus.waddr_o !== 32'hC0) begin n_bad++; $display("FAIL frz_waddr%0d: got %h expected c0", i, bus.waddr_o); end
      cyc();
    end
    bus.rdy = 1'b1;
    idle();
    #2;
    n_cmp++; if (bus.flush_o !== 1'b1) begin n_bad++; $display("FAIL frz_resume_flush: got %b expected 1", bus.flush_o); end
    n_cmp++; if (bus.we_o !== 1'b1) begin n_bad++; $display("FAIL frz_resume_we: got %b expected 1", bus.we_o); end
    n_cmp++; if (bus.waddr_o !== 32'hC0) begin n_bad++; $display("FAIL frz_resume_waddr0: got %h expected c0", bus.waddr_o); end
    cyc();
    #2;
    n_cmp++; if (bus.flush_o !== 1'b0) begin n_bad++; $display("FAIL frz_flush_done: got %b expected 0", bus.flush_o); end
    n_cmp++; if (bus.waddr_o !== 32'hC4) begin n_bad++; $display("FAIL frz_resume_waddr1: got %h expected c4", bus.waddr_o); end
    n_cmp++; if (bus.res_taken_o !== 1'b0) begin n_bad++; $display("FAIL frz_resume_res1: got %b expected 0", bus.res_taken_o); end
    cyc();
    #2;
    n_cmp++; if (bus.we_o !== 1'b0) begin n_bad++; $display("FAIL frz_empty_we: got %b expected 0", bus.we_o); end
    n_cmp++; if (bus.stat_branch_o !== 32'd2) begin n_bad++; $display("FAIL frz_final_branch: got %0d expected 2", bus.stat_branch_o); end
    cyc();
    $display("test_rdy_freeze done");
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.upd_ready_i = 1'b0;
    drive(1'b1, 32'hE0, 1'b1, 1'b1, 32'h0);
    cyc();
    drive(1'b1, 32'hE4, 1'b1, 1'b1, 32'h0);
    cyc();
    drive(1'b1, 32'hE8, 1'b0, 1'b1, 32'h0);
    cyc();
    idle();
    bus.upd_ready_i = 1'b1;
    #2;
    n_cmp++; if (bus.flush_o !== 1'b1) begin n_bad++; $display("FAIL ar_pre_flush: got %b expected 1", bus.flush_o); end
    n_cmp++; if (bus.we_o !== 1'b1) begin n_bad++; $display("FAIL ar_pre_we: got %b expected 1", bus.we_o); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.flush_o !== 1'b0) begin n_bad++; $display("FAIL ar_flush: got %b expected 0", bus.flush_o); end
    n_cmp++; if (bus.we_o !== 1'b0) begin n_bad++; $display("FAIL ar_we: got %b expected 0", bus.we_o); end
    n_cmp++; if (bus.waddr_o !== 32'h0) begin n_bad++; $display("FAIL ar_waddr: got %h expected 0", bus.waddr_o); end
    n_cmp++; if (bus.redirect_pc_o !== 32'h0) begin n_bad++; $display("FAIL ar_redirect: got %h expected 0", bus.redirect_pc_o); end
    n_cmp++; if (bus.stat_branch_o !== 32'd0) begin n_bad++; $display("FAIL ar_stat_branch: got %0d expected 0", bus.stat_branch_o); end
    n_cmp++; if (bus.stat_miss_o !== 32'd0) begin n_bad++; $display("FAIL ar_stat_miss: got %0d expected 0", bus.stat_miss_o); end
    n_cmp++; if (bus.br_ready_o !== 1'b1) begin n_bad++; $display("FAIL ar_ready: got %b expected 1", bus.br_ready_o); end
    cyc();
    rst_n = 1'b1;
    drive(1'b1, 32'hF0, 1'b1, 1'b1, 32'h0);
    #2;
    n_cmp++; if (bus.we_o !== 1'b0) begin n_bad++; $display("FAIL ar_post_empty: got %b expected 0", bus.we_o); end
    cyc();
    idle();
    #2;
    n_cmp++; if (bus.we_o !== 1'b1) begin n_bad++; $display("FAIL ar_post_we: got %b expected 1", bus.we_o); end
    n_cmp++; if (bus.waddr_o !== 32'hF0) begin n_bad++; $display("FAIL ar_post_waddr: got %h expected f0", bus.waddr_o); end
    n_cmp++; if (bus.stat_branch_o !== 32'd1) begin n_bad++; $display("FAIL ar_post_branch: got %0d expected 1", bus.stat_branch_o); end
    cyc();
    $display("test_async_reset done");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.rdy = 1'b1;
    bus.upd_ready_i = 1'b0;
    idle();
    cyc();
    test_reset();
    test_correct_pred();
    test_mispredict();
    test_full();
    test_push_pop();
    test_rdy_freeze();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_update_queue.md
# branch_update_queue

Resolution-side companion of the 2-bit branch predictor. Takes resolved conditional branches from EX and compares each actual outcome with the prediction carried down the pipeline. On a mismatch it raises a one-cycle flush with the corrected PC. Every accepted outcome is buffered in a small FIFO and drained, one per cycle, into the predictor's write port (we/waddr/res_taken).

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- ADDR_W, 32: instruction address width (InstAddrBus).
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global ready; low freezes all state
- br_valid_i  in  1  EX presents a resolved conditional branch
- br_ready_o  out  1  queue can accept (count != DEPTH)
- br_pc_i  in  ADDR_W  branch instruction address
- br_taken_i  in  1  actual outcome
- br_pred_i  in  1  predicted outcome carried with the instruction
- br_target_i  in  ADDR_W  taken target
- flush_o  out  1  registered mispredict pulse
- redirect_pc_o  out  ADDR_W  corrected fetch PC, valid with flush_o
- upd_ready_i  in  1  predictor write port available this cycle
- we_o  out  1  predictor write enable
- waddr_o  out  ADDR_W  predictor write address (head entry PC)
- res_taken_o  out  1  head entry outcome
- stat_branch_o  out  32  accepted branch count
- stat_miss_o  out  32  mispredict count

## Operation
- Accept = rdy && br_valid_i && br_ready_o && !flush_o.
  - On accept: enqueue {br_pc_i, br_taken_i} at the tail.
  - On accept: stat_branch_o += 1.
- Mispredict = accept && (br_taken_i != br_pred_i).
  - Next cycle: flush_o=1 and stat_miss_o += 1.
  - redirect_pc_o = br_taken_i ? br_target_i : br_pc_i + 4 (ADDR_W-bit wrap).
- br_valid_i is ignored (not enqueued, not counted) in any cycle where flush_o=1; that cycle is wrong-path.
- Drain: we_o = rdy && !empty && upd_ready_i.
  - waddr_o and res_taken_o always show the head entry, or 0 when empty.
  - The head pops in the same cycle that we_o=1.
- Simultaneous push and pop: count unchanged, FIFO order preserved.
- br_ready_o = (count != DEPTH); a push is refused when full, even if a pop occurs that cycle.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- Statistics counters wrap modulo 2^32.
- rdy=0:
  - No push, pop, counter or flush update; all registers hold.
  - we_o=0.
  - flush_o holds its registered value.

## Timing
- Reset (rst_n low, asynchronous):
  - Count, pointers and stats are 0; pending flush is cancelled.
  - Outputs: flush_o=0, redirect_pc_o=0, we_o=0, waddr_o=0, res_taken_o=0, stat_branch_o=0, stat_miss_o=0, br_ready_o=1.
  - Reset mid-operation discards all queued entries.
- Flush latency: branch accepted in cycle N gives flush_o=1 in N+1 only (rdy=1 assumed), then 0 in N+2 unless another mispredict was accepted in N+1. That second accept is impossible, because accepts are blocked while flush_o=1.
- Update latency: entry accepted in cycle N appears at the head at N+1 at the earliest. There is no empty-queue bypass.
- we_o, waddr_o and res_taken_o are combinational from head state, rdy and upd_ready_i.
- flush_o, redirect_pc_o and the stats are registered.

## Structure
- Shared package: ADDR_W default, typedef of the queue entry {pc[ADDR_W-1:0], taken}, the instruction-size constant 4.
- One sub-module: bq_fifo, a generic synchronous FIFO.
  - Parameters: DEPTH and entry width.
  - Ports: push, pop, full, empty, head data; async active-low reset.
- Mispredict compare, redirect mux and counters live in the top module.

## Test plan
- Correct prediction: reset; accept pc=0x100, taken=1, pred=1, upd_ready_i=1.
  - Next cycle: we_o=1, waddr_o=0x100, res_taken_o=1.
  - flush_o stays 0; stat_branch_o=1, stat_miss_o=0.
- Mispredict: accept pc=0x200, taken=0, pred=1, target=0x400.
  - Next cycle: flush_o=1, redirect_pc_o=0x204, stat_miss_o=1.
  - br_valid_i held in the flush cycle is dropped: stat_branch_o stays 1.
- Full queue: upd_ready_i=0; push 5 branches, one per cycle.
  - After 4 pushes br_ready_o=0 and the 5th is refused.
  - Raise upd_ready_i: 4 writes in push order on consecutive cycles, then we_o=0.
- Push and pop together: count=2 with upd_ready_i=1, push each cycle for 3 cycles.
  - br_ready_o stays 1; waddr_o sequence matches push order.
- rdy freeze: queue holds 2 entries and flush_o=1; drop rdy for 3 cycles.
  - we_o=0, flush_o stays 1, count and stats unchanged.
  - Raising rdy resumes exactly where it stopped.
- Async reset: assert rst_n=0 mid-cycle with 3 entries queued and flush pending.
  - Outputs clear immediately without a clock edge; br_ready_o=1.
  - After release, the first write seen is the next new branch.
